icache_responder: RTL and testbench

- Direct-mapped, read-only instruction cache that answers the fetch-stage instruction read port (address in, word out, one-cycle synchronous latency, like a block RAM).
- On a miss it raises a stall to the pipeline.
- It then refills one line from main memory over a word-serial request/valid interface.
- Sits between the IF/ID fetch path and the instruction memory.

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_line_array.sv | 60 ++++++
 rtl/icache_responder.sv | 143 ++++++++++++++
 tb/tb_icache_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address slicing helpers for the instruction cache.
package icache_pkg;

    localparam int LINE_ADDR_LEN_DEF = 3;
    localparam int SET_ADDR_LEN_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [31:0] addr_word(input logic [31:0] addr, input int line_len);
        return (addr >> 2) & ((32'd1 << line_len) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_set(input logic [31:0] addr, input int line_len,
                                             input int set_len);
        return (addr >> (2 + line_len)) & ((32'd1 << set_len) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int line_len,
                                             input int set_len);
        return addr >> (2 + line_len + set_len);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Tag/valid/data storage for the direct-mapped cache: one combinational read
// port, one word write port, a tag write that marks the line valid, and clear-all.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF,
    parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SET_ADDR_LEN-1:0]  rd_set,
    input  logic [LINE_ADDR_LEN-1:0] rd_word,
    output logic                     rd_valid,
    output logic [TAG_ADDR_LEN-1:0]  rd_tag,
    output logic [31:0]              rd_data,
    input  logic                     wr_en,
    input  logic [SET_ADDR_LEN-1:0]  wr_set,
    input  logic [LINE_ADDR_LEN-1:0] wr_word,
    input  logic [31:0]              wr_data,
    input  logic                     fill_en,
    input  logic [TAG_ADDR_LEN-1:0]  fill_tag,
    input  logic                     clear_all
);

    localparam int NUM_SETS  = 1 << SET_ADDR_LEN;
    localparam int NUM_WORDS = 1 << (SET_ADDR_LEN + LINE_ADDR_LEN);

    logic [NUM_SETS-1:0]     valid;
    logic [TAG_ADDR_LEN-1:0] tag_mem  [NUM_SETS];
    logic [31:0]             data_mem [NUM_WORDS];

    assign rd_valid = valid[rd_set];
    assign rd_tag   = tag_mem[rd_set];
    assign rd_data  = data_mem[{rd_set, rd_word}];

    // Only the valid bits are reset; an invalid line's tag and data are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clear_all) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[wr_set] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[wr_set] <= fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_set, wr_word}] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache with word-serial line refill.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache_responder
    import icache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic [31:0] rd_data,
    output logic        miss,
    input  logic        invalidate,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;

    state_t                   state;
    logic [TAG_ADDR_LEN-1:0]  lat_tag;
    logic [SET_ADDR_LEN-1:0]  lat_set;
    logic [LINE_ADDR_LEN-1:0] counter;
    logic                     pend_inv;

    logic [LINE_ADDR_LEN-1:0] req_word;
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [TAG_ADDR_LEN-1:0]  req_tag;

    logic                     arr_valid;
    logic [TAG_ADDR_LEN-1:0]  arr_tag;
    logic [31:0]              arr_data;
    logic                     hit;
    logic                     wr_en;
    logic                     fill_en;
    logic                     clear_all;

    assign req_word = LINE_ADDR_LEN'(addr_word(req_addr, LINE_ADDR_LEN));
    assign req_set  = SET_ADDR_LEN'(addr_set(req_addr, LINE_ADDR_LEN, SET_ADDR_LEN));
    assign req_tag  = TAG_ADDR_LEN'(addr_tag(req_addr, LINE_ADDR_LEN, SET_ADDR_LEN));

    assign hit  = arr_valid && (arr_tag == req_tag);
    assign miss = (state != IDLE) || (req_valid && !hit);

    // A deferred invalidate lands on the DONE->IDLE edge so the line just filled is dropped too.
    assign wr_en     = (state == REFILL) && mem_rvalid;
    assign fill_en   = wr_en && (counter == '1);
    assign clear_all = ((state == IDLE) && invalidate) ||
                       ((state == DONE) && (pend_inv || invalidate));

    icache_line_array #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .SET_ADDR_LEN  (SET_ADDR_LEN),
        .TAG_ADDR_LEN  (TAG_ADDR_LEN)
    ) u_line_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_set    (req_set),
        .rd_word   (req_word),
        .rd_valid  (arr_valid),
        .rd_tag    (arr_tag),
        .rd_data   (arr_data),
        .wr_en     (wr_en),
        .wr_set    (lat_set),
        .wr_word   (counter),
        .wr_data   (mem_rdata),
        .fill_en   (fill_en),
        .fill_tag  (lat_tag),
        .clear_all (clear_all)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_data  <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            counter  <= '0;
            pend_inv <= 1'b0;
            lat_tag  <= '0;
            lat_set  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && hit) begin
                        rd_data <= arr_data;
                    end else if (req_valid) begin
                        lat_tag  <= req_tag;
                        lat_set  <= req_set;
                        mem_addr <= {req_tag, req_set, {(LINE_ADDR_LEN + 2){1'b0}}};
                        mem_req  <= 1'b1;
                        counter  <= '0;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (invalidate) begin
                        pend_inv <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        counter <= counter + LINE_ADDR_LEN'(1);
                        if (counter == '1) begin
                            mem_req <= 1'b0;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    pend_inv <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state == IDLE) && req_valid) begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: vector table of fetches plus hand-written corner sequences.
module tb_icache_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] rd_data;
    logic        miss;
    logic        invalidate;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .rd_data    (rd_data),
        .miss       (miss),
        .invalidate (invalidate),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        exp_miss;
        logic [31:0] line_base;
        int          gap;
        logic        inv_mid;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rd(input string name);
        if (exp_q.size() == 0) begin
            total++;
            $display("[TB] FAIL %s: scoreboard empty, got 0x%08h expected none", name, rd_data);
        end else begin
            check(name, rd_data, exp_q.pop_front());
        end
    endtask

    // Fixed-schedule fetch: for a miss the bench acts as memory and serves 8 beats.
    task automatic do_fetch(input logic [31:0] addr, input logic exp_miss,
                            input logic [31:0] line_base, input int gap, input logic inv_mid);
        logic [31:0] exp_word;
        exp_word  = line_base + {29'd0, addr[4:2]};
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        check("miss_on_request", {31'd0, miss}, {31'd0, exp_miss});
        if (exp_miss) begin
            tick();
            check("mem_req_raised", {31'd0, mem_req}, 32'd1);
            check("mem_addr", mem_addr, {addr[31:5], 5'd0});
            for (int i = 0; i < 8; i++) begin
                for (int g = 0; g < gap; g++) begin
                    mem_rvalid = 1'b0;
                    check("miss_during_gap", {31'd0, miss}, 32'd1);
                    tick();
                end
                mem_rvalid = 1'b1;
                mem_rdata  = line_base + i;
                invalidate = inv_mid && (i == 3);
                tick();
                invalidate = 1'b0;
                mem_rvalid = 1'b0;
            end
            check("miss_in_done", {31'd0, miss}, 32'd1);
            check("mem_req_dropped", {31'd0, mem_req}, 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
            tick();
            mem_rvalid = 1'b0;
            if (inv_mid) begin
                check("miss_after_pending_inv", {31'd0, miss}, 32'd1);
                req_valid = 1'b0;
                tick();
                return;
            end
            check("miss_cleared_after_fill", {31'd0, miss}, 32'd0);
        end
        exp_q.push_back(exp_word);
        tick();
        check_rd("rd_data");
        check("no_mem_req_on_hit", {31'd0, mem_req}, 32'd0);
        req_valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{32'h0000_0040, 1'b1, 32'h0000_00A0, 0, 1'b0};
        vecs[1] = '{32'h0000_005C, 1'b0, 32'h0000_00A0, 0, 1'b0};
        vecs[2] = '{32'h0000_0044, 1'b0, 32'h0000_00A0, 0, 1'b0};
        vecs[3] = '{32'h0000_0240, 1'b1, 32'h0000_00B0, 0, 1'b0};
        vecs[4] = '{32'h0000_0040, 1'b1, 32'h0000_00A0, 2, 1'b0};
        vecs[5] = '{32'h0000_0058, 1'b0, 32'h0000_00A0, 0, 1'b0};
        vecs[6] = '{32'h0000_1000, 1'b1, 32'h0000_00C0, 0, 1'b1};
        vecs[7] = '{32'h0000_1004, 1'b1, 32'h0000_00C0, 0, 1'b0};
        vecs[8] = '{32'h0000_0040, 1'b1, 32'h0000_00A0, 0, 1'b0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        invalidate = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) tick();
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_miss_idle", {31'd0, miss}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 9; v++) begin
            do_fetch(vecs[v].addr, vecs[v].exp_miss, vecs[v].line_base,
                     vecs[v].gap, vecs[v].inv_mid);
        end

        // Invalidate in IDLE with a simultaneous hit: data returned, then the line is gone.
        req_valid  = 1'b1;
        req_addr   = 32'h0000_004C;
        invalidate = 1'b1;
        #1;
        check("inv_idle_hit_miss", {31'd0, miss}, 32'd0);
        exp_q.push_back(32'h0000_00A3);
        tick();
        invalidate = 1'b0;
        check_rd("inv_idle_rd_data");
        check("inv_idle_then_miss", {31'd0, miss}, 32'd1);
        req_valid = 1'b0;
        tick();

        // Reset asserted at beat 4 of a refill.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0800;
        #1;
        check("rst_refill_miss", {31'd0, miss}, 32'd1);
        tick();
        check("rst_refill_mem_addr", mem_addr, 32'h0000_0800);
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h0000_00D0 + i;
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        rst_n      = 1'b0;
        #1;
        check("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_mem_addr", mem_addr, 32'd0);
        check("rst_mid_rd_data", rd_data, 32'd0);
        tick();
        req_valid = 1'b0;
        rst_n     = 1'b1;
        mem_rdata = 32'h2222_2222;
        tick();
        tick();
        mem_rvalid = 1'b0;
        check("stray_rvalid_no_req", {31'd0, mem_req}, 32'd0);
        tick();

        do_fetch(32'h0000_0800, 1'b1, 32'h0000_00D0, 1, 1'b0);
        do_fetch(32'h0000_081C, 1'b0, 32'h0000_00D0, 0, 1'b0);
        do_fetch(32'h0000_0040, 1'b1, 32'h0000_00A0, 0, 1'b0);
        do_fetch(32'h0000_0060, 1'b1, 32'h0000_00E0, 0, 1'b0);
        do_fetch(32'h0000_0040, 1'b0, 32'h0000_00A0, 0, 1'b0);

        if (exp_q.size() != 0) begin
            total++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
